// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory game. This is a Moore FSM that sequences the
// datapath: the address counter (E), the round counter (Rod), the timeout
// timer (T), the first-play display timer (P), the play register (R) and the
// synchronous RAM write.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-low reset
//   iniciar               start request (level)
//   fimE, fimRod          address / round counter RCO (fimE is not used)
//   fimT, fimP            timeout timer end / first-play display timer end
//   igual                 memory data equals the registered play
//   enderecoIgualRodada   address equals round
//   jogada_feita          one-cycle play pulse
//   zera*/conta*          counter and timer controls
//   zeraR, registraR, we  play register and RAM write controls
//   sinal_led             1 = LEDs show memory data, 0 = LEDs show switches
//   pronto, acertou, errou, timeout   result flags
//   db_estado             current state code
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimE,
  input  logic       fimRod,
  input  logic       fimT,
  input  logic       fimP,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       jogada_feita,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraP,
  output logic       contaP,
  output logic       zeraR,
  output logic       registraR,
  output logic       we,
  output logic       sinal_led,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial        = 4'h0,
    StPreparacao     = 4'h1,
    StMostraPrimeira = 4'h2,
    StInicioRodada   = 4'h3,
    StEsperaJogada   = 4'h4,
    StRegistra       = 4'h5,
    StComparacao     = 4'h6,
    StProximo        = 4'h7,
    StIncrementaNova = 4'h8,
    StEsperaNova     = 4'h9,
    StRegistraNova   = 4'hA,
    StEscreve        = 4'hB,
    StProximaRodada  = 4'hC,
    StFimAcertou     = 4'hD,
    StFimErrou       = 4'hE,
    StFimTimeout     = 4'hF
  } estado_e;

  estado_e estado_q, estado_d;

  // The address counter RCO plays no role in sequencing.
  logic unused_fime;
  assign unused_fime = fimE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      StInicial:        if (iniciar) estado_d = StPreparacao;
      StPreparacao:     estado_d = StMostraPrimeira;
      StMostraPrimeira: if (fimP) estado_d = StInicioRodada;
      StInicioRodada:   estado_d = StEsperaJogada;
      // A play in the same cycle as the timeout still counts.
      StEsperaJogada: begin
        if (jogada_feita)  estado_d = StRegistra;
        else if (fimT)     estado_d = StFimTimeout;
      end
      StRegistra:       estado_d = StComparacao;
      StComparacao: begin
        if (!igual)                    estado_d = StFimErrou;
        else if (!enderecoIgualRodada) estado_d = StProximo;
        else if (fimRod)               estado_d = StFimAcertou;
        else                           estado_d = StIncrementaNova;
      end
      StProximo:        estado_d = StEsperaJogada;
      StIncrementaNova: estado_d = StEsperaNova;
      StEsperaNova: begin
        if (jogada_feita)  estado_d = StRegistraNova;
        else if (fimT)     estado_d = StFimTimeout;
      end
      StRegistraNova:   estado_d = StEscreve;
      StEscreve:        estado_d = StProximaRodada;
      StProximaRodada:  estado_d = StInicioRodada;
      StFimAcertou, StFimErrou, StFimTimeout: begin
        if (iniciar) estado_d = StPreparacao;
      end
      default:          estado_d = StInicial;
    endcase
  end

  // Moore output decode.
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraRod   = 1'b0;
    contaRod  = 1'b0;
    zeraT     = 1'b0;
    contaT    = 1'b0;
    zeraP     = 1'b0;
    contaP    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    we        = 1'b0;
    sinal_led = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    unique case (estado_q)
      StPreparacao: begin
        zeraE   = 1'b1;
        zeraRod = 1'b1;
        zeraR   = 1'b1;
        zeraT   = 1'b1;
        zeraP   = 1'b1;
      end
      StMostraPrimeira: begin
        contaP    = 1'b1;
        sinal_led = 1'b1;
      end
      StInicioRodada: begin
        zeraE = 1'b1;
        zeraT = 1'b1;
      end
      StEsperaJogada, StEsperaNova: contaT = 1'b1;
      StRegistra, StRegistraNova:   registraR = 1'b1;
      StProximo, StIncrementaNova: begin
        contaE = 1'b1;
        zeraT  = 1'b1;
      end
      StEscreve:       we = 1'b1;
      StProximaRodada: contaRod = 1'b1;
      StFimAcertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      StFimErrou: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      StFimTimeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule
